// File: rtl/alu_pkg.sv
// Shared ALU control codes and sequencer state encoding for the
// execute-stage ALU sharing logic.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_XOR = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_ADD = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SRA = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_mul(input logic [2:0] op);
    return op == ALU_MUL;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin grant; a tie goes to the requester that did not win last.
module rr_arb2 (
  input  logic       en,
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (en) begin
      unique case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last ? 2'b01 : 2'b10;
        default: grant = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one execute-stage ALU between two requesters: round-robin accept,
// hold ALU inputs for the op latency, return the captured result.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  logic [5:0]  req_op_i,
  input  logic [63:0] req_a_i,
  input  logic [63:0] req_b_i,
  output logic [1:0]  resp_valid_o,
  input  logic [1:0]  resp_ready_i,
  output logic [31:0] resp_data_o,
  output logic [2:0]  alu_ctrl_o,
  output logic [31:0] alu_data1_o,
  output logic [31:0] alu_data2_o,
  input  logic [31:0] alu_result_i,
  output logic        busy_o
);

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

  state_t      state, state_next;
  logic        last_grant;
  logic        owner;
  logic [3:0]  cnt;
  logic [1:0]  grant;
  logic        accept;
  logic        acc_idx;
  logic [2:0]  sel_op;
  logic [31:0] sel_a;
  logic [31:0] sel_b;

  rr_arb2 u_arb (
    .en    (state == IDLE),
    .req   (req_valid_i),
    .last  (last_grant),
    .grant (grant)
  );

  assign req_ready_o = grant;
  assign accept      = |(req_valid_i & grant);
  assign acc_idx     = grant[1];
  assign sel_op      = acc_idx ? req_op_i[5:3]  : req_op_i[2:0];
  assign sel_a       = acc_idx ? req_a_i[63:32] : req_a_i[31:0];
  assign sel_b       = acc_idx ? req_b_i[63:32] : req_b_i[31:0];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    resp_valid_o = '0;
    busy_o       = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (accept) state_next = EXEC;
      end
      EXEC: begin
        if (cnt == '0) state_next = RESP;
      end
      RESP: begin
        resp_valid_o[owner] = 1'b1;
        if (resp_ready_i[owner]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ALU inputs are only written on accept so they stay stable through EXEC
  // and RESP; the result register is written once, on the last EXEC cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      cnt         <= '0;
      alu_ctrl_o  <= '0;
      alu_data1_o <= '0;
      alu_data2_o <= '0;
      resp_data_o <= '0;
    end else begin
      if (accept) begin
        alu_ctrl_o  <= sel_op;
        alu_data1_o <= sel_a;
        alu_data2_o <= sel_b;
        last_grant  <= acc_idx;
        owner       <= acc_idx;
        cnt         <= is_mul(sel_op) ? MUL_CNT : '0;
      end
      if (state == EXEC) begin
        if (cnt != '0) begin
          cnt <= cnt - 4'd1;
        end else begin
          resp_data_o <= alu_result_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Randomised bench for alu_share_ctrl against a transaction-level model
// with a behavioural ALU attached to the DUT's ALU ports.
module tb_alu_share_ctrl;

  localparam int MUL_LAT = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [5:0]  req_op_i;
  logic [63:0] req_a_i;
  logic [63:0] req_b_i;
  logic [1:0]  resp_valid_o;
  logic [1:0]  resp_ready_i;
  logic [31:0] resp_data_o;
  logic [2:0]  alu_ctrl_o;
  logic [31:0] alu_data1_o;
  logic [31:0] alu_data2_o;
  logic [31:0] alu_result_i;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0]  pv;
  logic [2:0]  pop [2];
  logic [31:0] pa  [2];
  logic [31:0] pb  [2];
  int          last_w;

  alu_share_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_data_o  (resp_data_o),
    .alu_ctrl_o   (alu_ctrl_o),
    .alu_data1_o  (alu_data1_o),
    .alu_data2_o  (alu_data2_o),
    .alu_result_i (alu_result_i),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a ^ b;
      3'b010:  return a << b[4:0];
      3'b011:  return a + b;
      3'b100:  return a - b;
      3'b101:  return a * b;
      3'b110:  return $signed(a) >>> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result_i = alu_ref(alu_ctrl_o, alu_data1_o, alu_data2_o);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_reqs();
    req_valid_i = pv;
    req_op_i    = {pop[1], pop[0]};
    req_a_i     = {pa[1], pa[0]};
    req_b_i     = {pb[1], pb[0]};
  endtask

  task automatic set_req(input int n, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    pv[n]  = 1'b1;
    pop[n] = op;
    pa[n]  = a;
    pb[n]  = b;
  endtask

  task automatic refill(input int n);
    pv[n]  = ($urandom_range(0, 3) != 0);
    pop[n] = 3'($urandom_range(0, 7));
    pa[n]  = $urandom;
    pb[n]  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
  endtask

  // One full transaction from request presentation to response accept.
  task automatic serve(input int bp, input bit do_refill, output int winner);
    int          w, lat, n;
    logic [2:0]  op;
    logic [31:0] a, b, exp_res;
    logic [1:0]  oh;
    bit          nb;
    drive_reqs();
    #1;
    w = (pv == 2'b11) ? (1 - last_w) : (pv[1] ? 1 : 0);
    oh = (w == 1) ? 2'b10 : 2'b01;
    check("req_ready_idle", {30'd0, req_ready_o}, {30'd0, oh});
    check("busy_idle", {31'd0, busy_o}, 32'd0);
    op = pop[w];
    a  = pa[w];
    b  = pb[w];
    exp_res = alu_ref(op, a, b);
    lat = (op == 3'b101) ? MUL_LAT : 1;
    @(posedge clk_i); #1;
    last_w = w;
    pv[w] = 1'b0;
    if (do_refill) refill(w);
    drive_reqs();
    #1;
    check("alu_ctrl", {29'd0, alu_ctrl_o}, {29'd0, op});
    check("alu_data1", alu_data1_o, a);
    check("alu_data2", alu_data2_o, b);
    check("busy_exec", {31'd0, busy_o}, 32'd1);
    check("req_ready_exec", {30'd0, req_ready_o}, 32'd0);
    n = 0;
    while (resp_valid_o == 2'b00 && n < 40) begin
      @(posedge clk_i); #1;
      n++;
      check("req_ready_busy", {30'd0, req_ready_o}, 32'd0);
      check("alu_hold", {alu_ctrl_o, alu_data1_o[28:0]}, {op, a[28:0]});
      check("alu_hold_b", alu_data2_o, b);
    end
    check("latency", n, lat);
    check("resp_valid", {30'd0, resp_valid_o}, {30'd0, oh});
    check("resp_data", resp_data_o, exp_res);
    for (int i = 0; i < bp; i++) begin
      nb = 1'($urandom_range(0, 1));
      resp_ready_i = (w == 1) ? {1'b0, nb} : {nb, 1'b0};
      @(posedge clk_i); #1;
      check("bp_valid", {30'd0, resp_valid_o}, {30'd0, oh});
      check("bp_data", resp_data_o, exp_res);
      check("bp_req_ready", {30'd0, req_ready_o}, 32'd0);
    end
    nb = 1'($urandom_range(0, 1));
    resp_ready_i = (w == 1) ? {1'b1, nb} : {nb, 1'b1};
    @(posedge clk_i); #1;
    resp_ready_i = 2'b00;
    check("busy_after_resp", {31'd0, busy_o}, 32'd0);
    check("resp_valid_after", {30'd0, resp_valid_o}, 32'd0);
    winner = w;
  endtask

  initial begin
    int w;
    pv = 2'b00;
    for (int i = 0; i < 2; i++) begin
      pop[i] = 3'b000;
      pa[i]  = '0;
      pb[i]  = '0;
    end
    last_w = 1;
    rst_i = 1'b0;
    resp_ready_i = 2'b00;
    drive_reqs();
    #2;
    check("rst_req_ready", {30'd0, req_ready_o}, 32'd0);
    check("rst_resp_valid", {30'd0, resp_valid_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_resp_data", resp_data_o, 32'd0);
    check("rst_alu", {29'd0, alu_ctrl_o}, 32'd0);
    check("rst_d1", alu_data1_o, 32'd0);
    check("rst_d2", alu_data2_o, 32'd0);
    #20 rst_i = 1'b1;
    @(posedge clk_i); #1;

    set_req(0, 3'b011, 32'd5, 32'd7);
    serve(0, 1'b0, w);
    check("add_owner", w, 0);

    set_req(1, 3'b101, 32'd6, 32'd7);
    serve(0, 1'b0, w);
    check("mul_owner", w, 1);

    set_req(0, 3'b100, 32'd9, 32'd4);
    set_req(1, 3'b001, 32'hF0, 32'hFF);
    for (int k = 0; k < 4; k++) begin
      serve(0, 1'b0, w);
      check("alternate", w, k % 2);
      if (w == 0) set_req(0, 3'b100, 32'd9, 32'd4);
      else        set_req(1, 3'b001, 32'hF0, 32'hFF);
    end
    pv = 2'b00;

    set_req(0, 3'b011, 32'd5, 32'd7);
    serve(5, 1'b0, w);

    set_req(1, 3'b111, 32'd3, 32'd4);
    serve(0, 1'b0, w);

    // Idle with nothing requested: nothing may be granted.
    pv = 2'b00;
    drive_reqs();
    repeat (2) begin
      @(posedge clk_i); #1;
      check("idle_busy", {31'd0, busy_o}, 32'd0);
      check("idle_ready", {30'd0, req_ready_o}, 32'd0);
    end

    refill(0);
    refill(1);
    for (int t = 0; t < 150; t++) begin
      if (pv == 2'b00) refill($urandom_range(0, 1));
      if (pv == 2'b00) set_req(0, 3'($urandom_range(0, 7)), $urandom, $urandom);
      serve($urandom_range(0, 3), 1'b1, w);
    end

    // Reset in the middle of a multiply; requester 0 owns it so a restored
    // last_grant is visible on the following tie.
    pv = 2'b00;
    resp_ready_i = 2'b00;
    set_req(0, 3'b101, 32'd6, 32'd7);
    drive_reqs();
    #1;
    @(posedge clk_i); #1;
    pv = 2'b00;
    drive_reqs();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
    check("mrst_busy", {31'd0, busy_o}, 32'd0);
    check("mrst_resp_valid", {30'd0, resp_valid_o}, 32'd0);
    check("mrst_req_ready", {30'd0, req_ready_o}, 32'd0);
    check("mrst_resp_data", resp_data_o, 32'd0);
    check("mrst_alu", {29'd0, alu_ctrl_o}, 32'd0);
    check("mrst_d1", alu_data1_o, 32'd0);
    check("mrst_d2", alu_data2_o, 32'd0);
    #2 rst_i = 1'b1;
    last_w = 1;
    repeat (6) begin
      @(posedge clk_i); #1;
      check("no_resp_after_rst", {30'd0, resp_valid_o}, 32'd0);
      check("idle_after_rst", {31'd0, busy_o}, 32'd0);
    end
    set_req(0, 3'b100, 32'd9, 32'd4);
    set_req(1, 3'b001, 32'hF0, 32'hFF);
    serve(0, 1'b0, w);
    check("tie_after_rst", w, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
